// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: four byte reads per word, little-endian assembly, valid/ready to decode.
// Optional misaligned-redirect trap enabled by defining FETCH_ALIGN_TRAP_EN.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_rd,
  output logic [31:0] mem_addr,
  input  logic [7:0]  mem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_word,
  output logic [31:0] inst_pc,
  output logic        fault
);

  typedef enum logic [2:0] {
    START = 3'd0,
    ISSUE = 3'd1,
    LAST  = 3'd2,
`ifdef FETCH_ALIGN_TRAP_EN
    FAULT = 3'd4,
`endif
    HOLD  = 3'd3
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] fetch_pc_reg, fetch_pc_next;
  logic [1:0]  cnt_reg, cnt_next;
  logic [31:0] inst_pc_reg;
  logic        capture_en;
  logic [1:0]  capture_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= START;
      fetch_pc_reg <= RESET_PC;
      cnt_reg      <= 2'd0;
      inst_pc_reg  <= 32'd0;
    end else begin
      state_reg    <= state_next;
      fetch_pc_reg <= fetch_pc_next;
      cnt_reg      <= cnt_next;
      if (state_reg == LAST) inst_pc_reg <= fetch_pc_reg;
    end
  end

  always_comb begin
    state_next    = state_reg;
    fetch_pc_next = fetch_pc_reg;
    cnt_next      = cnt_reg;
    mem_rd        = 1'b0;
    mem_addr      = fetch_pc_reg + {30'd0, cnt_reg};
    inst_valid    = 1'b0;
    fault         = 1'b0;
    case (state_reg)
      START: state_next = ISSUE;
      ISSUE: begin
        mem_rd   = 1'b1;
        cnt_next = cnt_reg + 2'd1;
        if (cnt_reg == 2'd3) state_next = LAST;
      end
      LAST: state_next = HOLD;
      HOLD: begin
        inst_valid = 1'b1;
        if (inst_ready) begin
          fetch_pc_next = fetch_pc_reg + 32'd4;
          cnt_next      = 2'd0;
          state_next    = ISSUE;
        end
      end
`ifdef FETCH_ALIGN_TRAP_EN
      FAULT: fault = 1'b1;
`endif
      default: state_next = START;
    endcase
    // Redirect overrides everything, including a handshake completing this cycle.
    if (redirect_valid) begin
      fetch_pc_next = redirect_pc;
      cnt_next      = 2'd0;
`ifdef FETCH_ALIGN_TRAP_EN
      state_next    = (redirect_pc[1:0] != 2'd0) ? FAULT : ISSUE;
`else
      state_next    = ISSUE;
`endif
    end
  end

  // Byte k arrives one cycle after its read, so ISSUE with cnt=k+1 (or LAST for k=3) captures it.
  assign capture_en  = ((state_reg == ISSUE) && (cnt_reg != 2'd0)) || (state_reg == LAST);
  assign capture_idx = (state_reg == LAST) ? 2'd3 : (cnt_reg - 2'd1);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] lane_reg;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          lane_reg <= 8'd0;
        end else if (capture_en && (capture_idx == 2'(gi))) begin
          lane_reg <= mem_rdata;
        end
      end
      assign inst_word[8*gi +: 8] = lane_reg;
    end
  endgenerate

  assign inst_pc = inst_pc_reg;

endmodule
